// File: rtl/dilithium_drv_pkg.sv
// Shared types, widths and per-level word counts for the Dilithium host driver.
package dilithium_drv_pkg;

    localparam int unsigned CNT_W  = 17;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEED_W = 8;

    typedef enum logic [1:0] {
        MODE_KEYGEN  = 2'd0,
        MODE_SIGN    = 2'd1,
        MODE_VERIFY  = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_RUN    = 3'd2,
        S_FINISH = 3'd3,
        S_ERR    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_MODE    = 2'd1,
        ERR_PROTO   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    function automatic int unsigned pk_w(input int unsigned lvl);
        case (lvl)
            3:       return 488;
            5:       return 648;
            default: return 328;
        endcase
    endfunction

    function automatic int unsigned sk_w(input int unsigned lvl);
        case (lvl)
            3:       return 1000;
            5:       return 1216;
            default: return 632;
        endcase
    endfunction

    function automatic int unsigned sig_w(input int unsigned lvl);
        case (lvl)
            3:       return 824;
            5:       return 1149;
            default: return 605;
        endcase
    endfunction

    // The extra word in sign/verify carries the message length itself.
    function automatic logic [CNT_W-1:0] in_words(input int unsigned lvl, input logic [1:0] mode,
                                                  input logic [15:0] msg);
        logic [CNT_W-1:0] words;
        case (mode)
            MODE_KEYGEN: words = CNT_W'(SEED_W);
            MODE_SIGN:   words = CNT_W'(sk_w(lvl) + 1) + CNT_W'(msg);
            MODE_VERIFY: words = CNT_W'(pk_w(lvl) + sig_w(lvl) + 1) + CNT_W'(msg);
            default:     words = '0;
        endcase
        return words;
    endfunction

    function automatic logic [CNT_W-1:0] out_words(input int unsigned lvl, input logic [1:0] mode);
        logic [CNT_W-1:0] words;
        case (mode)
            MODE_KEYGEN: words = CNT_W'(pk_w(lvl) + sk_w(lvl));
            MODE_SIGN:   words = CNT_W'(sig_w(lvl));
            MODE_VERIFY: words = CNT_W'(1);
            default:     words = '0;
        endcase
        return words;
    endfunction

endpackage

// File: rtl/dilithium_drv_counter.sv
// Saturating word counter; term flags that the count has reached its limit.
module dilithium_drv_counter
    import dilithium_drv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !term) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term = (cnt == limit);

endmodule

// File: rtl/dilithium_host_driver.sv
// Host-side initiator for the Dilithium wrapper: meters word counts per command, reports done/err.
// Optional watchdog enabled by defining DILITHIUM_DRV_TIMEOUT_EN.
module dilithium_host_driver
    import dilithium_drv_pkg::*;
#(
    parameter int unsigned SEC_LEVEL   = 2,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [15:0]       cmd_msg_words,
    input  logic              h_valid_i,
    output logic              h_ready_i,
    input  logic [DATA_W-1:0] h_data_i,
    output logic              h_valid_o,
    input  logic              h_ready_o,
    output logic [DATA_W-1:0] h_data_o,
    output logic              h_last_o,
    output logic              start,
    output logic [1:0]        mode,
    output logic              valid_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_i,
    input  logic              valid_o,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_o,
    input  logic              done_o,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam logic [2:0] ST_IDLE   = 3'(S_IDLE);
    localparam logic [2:0] ST_START  = 3'(S_START);
    localparam logic [2:0] ST_RUN    = 3'(S_RUN);
    localparam logic [2:0] ST_FINISH = 3'(S_FINISH);
    localparam logic [2:0] ST_ERR    = 3'(S_ERR);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] in_total_q, in_total_d, out_total_q, out_total_d;
    logic             done_seen_q, done_seen_d;
    logic             start_d, busy_d, done_d;
    logic [1:0]       mode_d, err_d;

    logic [CNT_W-1:0] in_cnt, out_cnt;
    logic             in_term, out_term;
    logic             run_c, accept_c, in_hs_c, out_hs_c;
    logic             in_full_c, out_full_c, proto_err_c, finish_c, tmo_hit_c;

    assign run_c     = (state_q == ST_RUN);
    assign cmd_ready = (state_q == ST_IDLE);
    assign accept_c  = cmd_valid && cmd_ready;

    // Stream pass-through, gated to RUN and to the remaining word budget.
    assign valid_i   = run_c && h_valid_i && !in_term;
    assign h_ready_i = run_c && ready_i && !in_term;
    assign data_i    = h_data_i;
    assign h_valid_o = run_c && valid_o;
    assign ready_o   = run_c && h_ready_o && !out_term;
    assign h_data_o  = data_o;
    assign h_last_o  = run_c && (out_cnt == out_total_q - CNT_W'(1));

    assign in_hs_c  = valid_i && ready_i;
    assign out_hs_c = valid_o && ready_o;

    dilithium_drv_counter u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_c),
        .inc   (in_hs_c),
        .limit (in_total_q),
        .cnt   (in_cnt),
        .term  (in_term)
    );

    dilithium_drv_counter u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_c),
        .inc   (out_hs_c),
        .limit (out_total_q),
        .cnt   (out_cnt),
        .term  (out_term)
    );

    // Counts that will be complete after this edge, so a final handshake and done_o can coincide.
    assign in_full_c   = in_term || (in_hs_c && (in_cnt == in_total_q - CNT_W'(1)));
    assign out_full_c  = out_term || (out_hs_c && (out_cnt == out_total_q - CNT_W'(1)));
    assign proto_err_c = valid_o && (out_term || done_seen_q);
    assign finish_c    = (done_o || done_seen_q) && in_full_c && out_full_c;

`ifdef DILITHIUM_DRV_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;

    // Idle-cycle watchdog; any handshake restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == ST_START || run_c) && !(in_hs_c || out_hs_c)) begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign tmo_hit_c = run_c && !(in_hs_c || out_hs_c) && (tmo_cnt_q == 32'(TIMEOUT_CYC - 1));
`else
    // Watchdog absent; TIMEOUT_CYC is kept only so both builds share one interface.
    assign tmo_hit_c = 1'b0 && (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_d     = state_q;
        in_total_d  = in_total_q;
        out_total_d = out_total_q;
        done_seen_d = done_seen_q;
        start_d     = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy;
        mode_d      = mode;
        err_d       = err;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (cmd_mode == MODE_ILLEGAL) begin
                        done_d = 1'b1;
                        err_d  = ERR_MODE;
                    end else begin
                        mode_d      = cmd_mode;
                        in_total_d  = in_words(SEC_LEVEL, cmd_mode, cmd_msg_words);
                        out_total_d = out_words(SEC_LEVEL, cmd_mode);
                        done_seen_d = 1'b0;
                        err_d       = ERR_OK;
                        busy_d      = 1'b1;
                        start_d     = 1'b1;
                        state_d     = ST_START;
                    end
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (proto_err_c) begin
                    err_d   = ERR_PROTO;
                    done_d  = 1'b1;
                    state_d = ST_ERR;
                end else if (tmo_hit_c) begin
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    state_d = ST_ERR;
                end else if (finish_c) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else if (done_o) begin
                    done_seen_d = 1'b1;
                end
            end
            ST_FINISH, ST_ERR: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_total_q  <= '0;
            out_total_q <= '0;
            done_seen_q <= 1'b0;
            start       <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            mode        <= '0;
            err         <= '0;
        end else begin
            state_q     <= state_d;
            in_total_q  <= in_total_d;
            out_total_q <= out_total_d;
            done_seen_q <= done_seen_d;
            start       <= start_d;
            done        <= done_d;
            busy        <= busy_d;
            mode        <= mode_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_dilithium_host_driver.sv
// Directed bench for dilithium_host_driver at SEC_LEVEL 2 with a cycle-level core/host model.
module tb_dilithium_host_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_msg_words;
    logic        h_valid_i, h_ready_i;
    logic [31:0] h_data_i;
    logic        h_valid_o, h_ready_o, h_last_o;
    logic [31:0] h_data_o;
    logic        start;
    logic [1:0]  mode;
    logic        valid_i, ready_i;
    logic [31:0] data_i;
    logic        valid_o, ready_o;
    logic [31:0] data_o;
    logic        done_o, busy, done;
    logic [1:0]  err;

    dilithium_host_driver #(.SEC_LEVEL(2), .TIMEOUT_CYC(50)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_msg_words (cmd_msg_words),
        .h_valid_i     (h_valid_i),
        .h_ready_i     (h_ready_i),
        .h_data_i      (h_data_i),
        .h_valid_o     (h_valid_o),
        .h_ready_o     (h_ready_o),
        .h_data_o      (h_data_o),
        .h_last_o      (h_last_o),
        .start         (start),
        .mode          (mode),
        .valid_i       (valid_i),
        .ready_i       (ready_i),
        .data_i        (data_i),
        .valid_o       (valid_o),
        .ready_o       (ready_o),
        .data_o        (data_o),
        .done_o        (done_o),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Results of the last run_op call.
    int   r_in, r_out, r_start, r_start_cyc, r_done_cyc, r_last, r_nlast;
    bit   r_done, r_ended, r_data_bad, r_rdy_after_full, r_ovf_ready;
    logic [1:0] r_err, r_mode;

    task automatic quiesce();
        cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_msg_words = 16'd0;
        h_valid_i = 1'b0; h_data_i = 32'd0; ready_i = 1'b0;
        valid_o = 1'b0; data_o = 32'd0; h_ready_o = 1'b0; done_o = 1'b0;
    endtask

    task automatic issue(input logic [1:0] m, input logic [15:0] msg);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = m; cmd_msg_words = msg;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Core emits core_out_n words once started, then pulses done_o after exp_in inputs.
    task automatic run_op(input int exp_in, input int exp_out, input int core_out_n, input bit core_rdy,
                          input bit bp, input int stop_in, input int max_cyc);
        bit active = 1'b0;
        bit done_given = 1'b0;
        int out_sent = 0;
        r_in = 0; r_out = 0; r_start = 0; r_start_cyc = -1; r_done_cyc = -1; r_last = 0; r_nlast = 0;
        r_done = 1'b0; r_ended = 1'b0; r_data_bad = 1'b0; r_rdy_after_full = 1'b0; r_ovf_ready = 1'b0;
        r_err = 2'd0; r_mode = 2'd0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            h_valid_i = 1'b1;
            h_data_i  = 32'h5000_0000 + 32'(r_in);
            ready_i   = core_rdy;
            valid_o   = active && (out_sent < core_out_n);
            data_o    = 32'hA000_0000 + 32'(out_sent);
            h_ready_o = bp ? ((cyc % 3) != 2) : 1'b1;
            done_o    = active && !done_given && (out_sent >= core_out_n) && (r_in >= exp_in);
            #1;
            if (start) begin
                r_start++;
                if (r_start == 1) begin
                    r_start_cyc = cyc; r_mode = mode; active = 1'b1;
                end
            end
            if (r_in >= exp_in && h_ready_i) r_rdy_after_full = 1'b1;
            if (valid_i && ready_i) begin
                if (data_i !== h_data_i) r_data_bad = 1'b1;
                r_in++;
            end
            if (valid_o && r_out >= exp_out && ready_o) r_ovf_ready = 1'b1;
            if (valid_o && ready_o) begin
                if (h_data_o !== data_o || !h_valid_o) r_data_bad = 1'b1;
                r_out++; out_sent++;
                if (h_last_o) begin r_last = r_out; r_nlast++; end
            end
            if (done_o) done_given = 1'b1;
            if (done) begin
                r_done = 1'b1; r_err = err; r_done_cyc = cyc; r_ended = 1'b1;
                break;
            end
            if (stop_in > 0 && r_in == stop_in) begin
                r_ended = 1'b1;
                break;
            end
        end
        check("op_bound", 32'(r_ended), 32'd1);
    endtask

    task automatic post_idle(input string tag);
        @(negedge clk);
        quiesce();
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_start"}, 32'(start), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_mode"}, 32'(mode), 32'd0);
        check({tag, "_valid_i"}, 32'(valid_i), 32'd0);
        check({tag, "_h_ready_i"}, 32'(h_ready_i), 32'd0);
        check({tag, "_ready_o"}, 32'(ready_o), 32'd0);
        check({tag, "_h_valid_o"}, 32'(h_valid_o), 32'd0);
    endtask

    initial begin
        quiesce();
        rst = 1'b1;
        h_valid_i = 1'b1; ready_i = 1'b1; valid_o = 1'b1; h_ready_o = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        quiesce();

        // Keygen with host output backpressure: 8 in, 960 out.
        issue(2'd0, 16'd0);
        run_op(8, 960, 960, 1'b1, 1'b1, 0, 5000);
        check("kg_start_lat", 32'(r_start_cyc), 32'd0);
        check("kg_starts", 32'(r_start), 32'd1);
        check("kg_mode", 32'(r_mode), 32'd0);
        check("kg_in", 32'(r_in), 32'd8);
        check("kg_out", 32'(r_out), 32'd960);
        check("kg_last_idx", 32'(r_last), 32'd960);
        check("kg_last_cnt", 32'(r_nlast), 32'd1);
        check("kg_data", 32'(r_data_bad), 32'd0);
        check("kg_err", 32'(r_err), 32'd0);
        post_idle("kg_post");

        // Sign msg=4: 632+1+4 = 637 in, 605 out.
        issue(2'd1, 16'd4);
        run_op(637, 605, 605, 1'b1, 1'b0, 0, 5000);
        check("sg_starts", 32'(r_start), 32'd1);
        check("sg_mode", 32'(r_mode), 32'd1);
        check("sg_in", 32'(r_in), 32'd637);
        check("sg_rdy_after_full", 32'(r_rdy_after_full), 32'd0);
        check("sg_out", 32'(r_out), 32'd605);
        check("sg_last_idx", 32'(r_last), 32'd605);
        check("sg_data", 32'(r_data_bad), 32'd0);
        check("sg_err", 32'(r_err), 32'd0);
        post_idle("sg_post");

        // Illegal mode: done next cycle, err=1, no start.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 2'd3;
        #1 check("il_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        check("il_done", 32'(done), 32'd1);
        check("il_err", 32'(err), 32'd1);
        check("il_start", 32'(start), 32'd0);
        check("il_cmd_ready2", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        #1;
        check("il_done_pulse", 32'(done), 32'd0);
        check("il_err_held", 32'(err), 32'd1);
        check("il_start2", 32'(start), 32'd0);

        // Verify msg=2 (936 in, 1 out); core pushes a second output word.
        issue(2'd2, 16'd2);
        run_op(936, 1, 2, 1'b1, 1'b0, 0, 3000);
        check("vf_out", 32'(r_out), 32'd1);
        check("vf_last_idx", 32'(r_last), 32'd1);
        check("vf_ovf_ready", 32'(r_ovf_ready), 32'd0);
        check("vf_done", 32'(r_done), 32'd1);
        check("vf_err", 32'(r_err), 32'd2);
        post_idle("vf_post");
        check("vf_err_held", 32'(err), 32'd2);

        // Reset mid-sign after 100 input words, then a clean keygen.
        issue(2'd1, 16'd4);
        run_op(637, 605, 605, 1'b1, 1'b0, 100, 3000);
        check("rs_in", 32'(r_in), 32'd100);
        check("rs_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1 check_reset_outputs("rs");
        rst = 1'b0;
        quiesce();
        issue(2'd0, 16'd0);
        run_op(8, 960, 960, 1'b1, 1'b0, 0, 3000);
        check("rk_in", 32'(r_in), 32'd8);
        check("rk_out", 32'(r_out), 32'd960);
        check("rk_last_idx", 32'(r_last), 32'd960);
        check("rk_err", 32'(r_err), 32'd0);
        post_idle("rk_post");

`ifdef DILITHIUM_DRV_TIMEOUT_EN
        // Core never ready: watchdog fires 50 cycles after the start cycle.
        issue(2'd1, 16'd4);
        run_op(637, 605, 0, 1'b0, 1'b0, 0, 500);
        check("to_done", 32'(r_done), 32'd1);
        check("to_lat", 32'(r_done_cyc - r_start_cyc), 32'd50);
        check("to_err", 32'(r_err), 32'd3);
        post_idle("to_post");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
